// File: rtl/vga_sync_detector_pkg.sv
// ---------------------------------------------------------------------------
// vga_sync_detector_pkg
// Shared width parameters for the VGA sync measurement path, plus the
// classification used when a measured low pulse cannot be expressed in the
// Counter's Sync_pulse encoding.
// ---------------------------------------------------------------------------
package vga_sync_detector_pkg;

    // Width of the period counter / Count_max encoding.
    localparam int REZ_MAX_WIDTH_DEF = 11;
    // Width of the Sync_pulse encoding.
    localparam int PULSE_WIDTH_DEF   = 8;
    // Consecutive matching measurements needed before Locked.
    localparam int LOCK_COUNT_DEF    = 4;

    // How a measured low width maps onto Sync_pulse.
    typedef enum logic [1:0] {
        FMT_OK     = 2'd0,
        FMT_NARROW = 2'd1,  // low width below 2, encodes as 0
        FMT_WIDE   = 2'd2   // too wide or not shorter than the period, encodes as all-ones
    } fmt_t;

endpackage

// File: rtl/vga_sync_detector_if.sv
// ---------------------------------------------------------------------------
// vga_sync_detector_if
// Bundles the raw sync line and the measurement results.
//   Sync_in     : raw active-low sync line (async to Clk)
//   Meas_valid  : one-cycle strobe, a new measurement is presented
//   Period_meas : period - 1 (Count_max encoding)
//   Pulse_meas  : low width - 2 (Sync_pulse encoding)
//   Locked      : stable timing detected
//   Timeout     : sticky loss-of-signal flag
//   Format_err  : last measurement not encodable
// master = the detector, slave = the configuration-bus side.
// ---------------------------------------------------------------------------
interface vga_sync_detector_if #(
    parameter int REZ_MAX_WIDTH = vga_sync_detector_pkg::REZ_MAX_WIDTH_DEF,
    parameter int PULSE_WIDTH   = vga_sync_detector_pkg::PULSE_WIDTH_DEF
);
    import vga_sync_detector_pkg::*;

    logic                     Sync_in;
    logic                     Meas_valid;
    logic [REZ_MAX_WIDTH-1:0] Period_meas;
    logic [PULSE_WIDTH-1:0]   Pulse_meas;
    logic                     Locked;
    logic                     Timeout;
    logic                     Format_err;

    modport master (
        input  Sync_in,
        output Meas_valid, Period_meas, Pulse_meas, Locked, Timeout, Format_err
    );

    modport slave (
        output Sync_in,
        input  Meas_valid, Period_meas, Pulse_meas, Locked, Timeout, Format_err
    );

endinterface

// File: rtl/vga_sync_detector_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchronizer for an idle-high line followed by an edge register.
//   Clk, Rst : clock, asynchronous active-low reset
//   Sync_in  : raw asynchronous line
//   Sync_s   : synchronized line
//   Fall_p   : high for one cycle on a synchronized falling edge
//   Rise_p   : high for one cycle on a synchronized rising edge
// All flops reset to 1 so no spurious edge is reported after reset.
// ---------------------------------------------------------------------------
module sync_edge_detect (
    input  logic Clk,
    input  logic Rst,
    input  logic Sync_in,
    output logic Sync_s,
    output logic Fall_p,
    output logic Rise_p
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = Sync_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign Sync_s = sync_q;
    assign Fall_p = prev_q & ~sync_q;
    assign Rise_p = ~prev_q & sync_q;

endmodule

// File: rtl/vga_sync_detector.sv
// ---------------------------------------------------------------------------
// vga_sync_detector
// Measures period and low-pulse width of one sync line and reports them in
// the Counter's Config encoding, declares lock after LOCK_COUNT consecutive
// identical measurements and flags loss of signal.
//   Clk : pixel clock
//   Rst : asynchronous active-low reset
//   bus : vga_sync_detector_if.master (Sync_in in, measurement results out)
// ---------------------------------------------------------------------------
module vga_sync_detector #(
    parameter int REZ_MAX_WIDTH = vga_sync_detector_pkg::REZ_MAX_WIDTH_DEF,
    parameter int PULSE_WIDTH   = vga_sync_detector_pkg::PULSE_WIDTH_DEF,
    parameter int LOCK_COUNT    = vga_sync_detector_pkg::LOCK_COUNT_DEF
) (
    input  logic                Clk,
    input  logic                Rst,
    vga_sync_detector_if.master bus
);
    import vga_sync_detector_pkg::*;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [REZ_MAX_WIDTH-1:0] CNT_ONE    = REZ_MAX_WIDTH'(1);
    localparam logic [REZ_MAX_WIDTH-1:0] CNT_TWO    = REZ_MAX_WIDTH'(2);
    localparam logic [REZ_MAX_WIDTH-1:0] CNT_MAX    = '1;
    // Widest low pulse whose (width - 2) still fits in PULSE_WIDTH bits.
    localparam logic [REZ_MAX_WIDTH-1:0] LOW_MAX_OK = REZ_MAX_WIDTH'((2 ** PULSE_WIDTH) + 1);
    localparam logic [3:0]               MATCH_TGT  = 4'(LOCK_COUNT - 1);

    logic sync_s, fall_p, rise_p;

    sync_edge_detect u_edge (
        .Clk    (Clk),
        .Rst    (Rst),
        .Sync_in(bus.Sync_in),
        .Sync_s (sync_s),
        .Fall_p (fall_p),
        .Rise_p (rise_p)
    );

    logic [1:0]               state_q, state_d;
    logic [3:0]               match_cnt_q, match_cnt_d;
    logic [REZ_MAX_WIDTH-1:0] period_q, period_d;
    logic [REZ_MAX_WIDTH-1:0] low_q, low_d;
    logic                     low_run_q, low_run_d;
    logic                     meas_valid_q, meas_valid_d;
    logic [REZ_MAX_WIDTH-1:0] period_meas_q, period_meas_d;
    logic [PULSE_WIDTH-1:0]   pulse_meas_q, pulse_meas_d;
    logic                     locked_q, locked_d;
    logic                     timeout_q, timeout_d;
    logic                     fmt_err_q, fmt_err_d;

    fmt_t                     meas_fmt;
    logic [REZ_MAX_WIDTH-1:0] meas_period;
    logic [PULSE_WIDTH-1:0]   meas_pulse;
    logic                     meas_match;
    logic                     timeout_hit;

    // Period and low-width counters; the count present at a falling edge is
    // the length of the line that just ended.
    always_comb begin
        period_d  = period_q;
        low_d     = low_q;
        low_run_d = low_run_q;
        if (fall_p) begin
            period_d  = CNT_ONE;
            low_d     = CNT_ONE;
            low_run_d = 1'b1;
        end else begin
            if (period_q != CNT_MAX) period_d = period_q + CNT_ONE;
            if (rise_p) begin
                low_run_d = 1'b0;
            end else if (low_run_q && !sync_s && (low_q != CNT_MAX)) begin
                low_d = low_q + CNT_ONE;
            end
        end
    end

    // Encode the measurement that completes on this falling edge.
    always_comb begin
        meas_period = period_q - CNT_ONE;
        if (low_q < CNT_TWO) begin
            meas_fmt = FMT_NARROW;
        end else if ((low_q > LOW_MAX_OK) || (low_q >= period_q)) begin
            meas_fmt = FMT_WIDE;
        end else begin
            meas_fmt = FMT_OK;
        end
        case (meas_fmt)
            FMT_NARROW: meas_pulse = '0;
            FMT_WIDE:   meas_pulse = '1;
            default:    meas_pulse = PULSE_WIDTH'(low_q - CNT_TWO);
        endcase
    end

    // Saturated pulse values could coincide with real ones, so an erroneous
    // measurement on either side never matches.
    assign meas_match = (meas_fmt == FMT_OK) && !fmt_err_q &&
                        (meas_period == period_meas_q) && (meas_pulse == pulse_meas_q);
    // An edge in the saturation cycle wins over the timeout.
    assign timeout_hit = !fall_p && (period_q == CNT_MAX);

    // State register (plus all other flops).
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_IDLE;
            match_cnt_q   <= '0;
            period_q      <= '0;
            low_q         <= '0;
            low_run_q     <= 1'b0;
            meas_valid_q  <= 1'b0;
            period_meas_q <= '0;
            pulse_meas_q  <= '0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_cnt_q   <= match_cnt_d;
            period_q      <= period_d;
            low_q         <= low_d;
            low_run_q     <= low_run_d;
            meas_valid_q  <= meas_valid_d;
            period_meas_q <= period_meas_d;
            pulse_meas_q  <= pulse_meas_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        if (timeout_hit) begin
            state_d     = ST_IDLE;
            match_cnt_d = '0;
        end else if (fall_p) begin
            case (state_q)
                ST_IDLE: state_d = ST_MEASURE;
                ST_MEASURE: begin
                    state_d     = ST_CHECK;
                    match_cnt_d = '0;
                end
                ST_CHECK: begin
                    if (meas_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d >= MATCH_TGT) state_d = ST_LOCKED;
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!meas_match) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: results move only with Meas_valid, except the timeout path.
    always_comb begin
        meas_valid_d  = 1'b0;
        period_meas_d = period_meas_q;
        pulse_meas_d  = pulse_meas_q;
        locked_d      = locked_q;
        timeout_d     = timeout_q;
        fmt_err_d     = fmt_err_q;
        if (timeout_hit) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
        end else if (fall_p) begin
            timeout_d = 1'b0;
            if (state_q != ST_IDLE) begin
                meas_valid_d  = 1'b1;
                period_meas_d = meas_period;
                pulse_meas_d  = meas_pulse;
                fmt_err_d     = (meas_fmt != FMT_OK);
                locked_d      = (state_d == ST_LOCKED);
            end
        end
    end

    assign bus.Meas_valid  = meas_valid_q;
    assign bus.Period_meas = period_meas_q;
    assign bus.Pulse_meas  = pulse_meas_q;
    assign bus.Locked      = locked_q;
    assign bus.Timeout     = timeout_q;
    assign bus.Format_err  = fmt_err_q;

endmodule
